// File: rtl/branch_target_lut.sv
// rtl/branch_target_lut.sv - programmable branch-target table with registered lookup
// Absolute/relative entries, write-first bypass, legacy defaults reloaded on reset.
module branch_target_lut #(
  parameter int D = 10,
  parameter int A = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [D-1:0] pc,
  input  logic         lk_req,
  input  logic [A-1:0] lk_addr,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic         wr_rel,
  input  logic [D-1:0] wr_data,
  output logic         lk_valid,
  output logic         lk_hit,
  output logic [D-1:0] target
);

  localparam int DEPTH = 2 ** A;

  logic         valid_q [DEPTH];
  logic         rel_q   [DEPTH];
  logic [D-1:0] data_q  [DEPTH];

  logic         lk_valid_q, lk_valid_d;
  logic         lk_hit_q, lk_hit_d;
  logic [D-1:0] target_q, target_d;

  logic         e_valid;
  logic         e_rel;
  logic [D-1:0] e_data;

  // Entry as seen by the lookup; a same-cycle write to the same index wins.
  always_comb begin
    e_valid = valid_q[lk_addr];
    e_rel   = rel_q[lk_addr];
    e_data  = data_q[lk_addr];
    if (wr_en && (wr_addr == lk_addr)) begin
      e_valid = 1'b1;
      e_rel   = wr_rel;
      e_data  = wr_data;
    end
  end

  always_comb begin
    lk_valid_d = lk_req;
    lk_hit_d   = lk_hit_q;
    target_d   = target_q;
    if (lk_req) begin
      lk_hit_d = e_valid;
      if (!e_valid) begin
        target_d = pc + D'(1);
      end else if (e_rel) begin
        target_d = pc + e_data;
      end else begin
        target_d = e_data;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        rel_q[i]   <= 1'b0;
        data_q[i]  <= '0;
      end
      // Legacy fixed-table contents.
      valid_q[0] <= 1'b1;
      valid_q[1] <= 1'b1;
      valid_q[2] <= 1'b1;
      data_q[0]  <= D'(0);
      data_q[1]  <= D'(9);
      data_q[2]  <= D'(17);
    end else if (wr_en) begin
      valid_q[wr_addr] <= 1'b1;
      rel_q[wr_addr]   <= wr_rel;
      data_q[wr_addr]  <= wr_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lk_valid_q <= 1'b0;
      lk_hit_q   <= 1'b0;
      target_q   <= '0;
    end else begin
      lk_valid_q <= lk_valid_d;
      lk_hit_q   <= lk_hit_d;
      target_q   <= target_d;
    end
  end

  assign lk_valid = lk_valid_q;
  assign lk_hit   = lk_hit_q;
  assign target   = target_q;

endmodule

// File: tb/tb_branch_target_lut.sv
// tb/tb_branch_target_lut.sv - directed table-driven bench for branch_target_lut
// Each vector drives one cycle and checks the registered result after that edge.
module tb_branch_target_lut;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [9:0] pc;
  logic       lk_req;
  logic [3:0] lk_addr;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic       wr_rel;
  logic [9:0] wr_data;
  logic       lk_valid;
  logic       lk_hit;
  logic [9:0] target;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  branch_target_lut #(.D(10), .A(4)) dut (
    .Clk(Clk), .Reset(Reset), .pc(pc), .lk_req(lk_req), .lk_addr(lk_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_rel(wr_rel), .wr_data(wr_data),
    .lk_valid(lk_valid), .lk_hit(lk_hit), .target(target)
  );

  typedef struct {
    logic       req;
    logic [3:0] addr;
    logic [9:0] pc;
    logic       we;
    logic [3:0] wa;
    logic       wrel;
    logic [9:0] wd;
    logic       ev;
    logic       eh;
    logic [9:0] et;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic req, input int addr, input int p,
                              input logic we, input int wa, input logic wrel, input int wd,
                              input logic ev, input logic eh, input int et);
    vec_t v;
    v.req = req; v.addr = 4'(addr); v.pc = 10'(p);
    v.we = we; v.wa = 4'(wa); v.wrel = wrel; v.wd = 10'(wd);
    v.ev = ev; v.eh = eh; v.et = 10'(et);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input vec_t v);
    @(negedge Clk);
    Reset = rst; lk_req = v.req; lk_addr = v.addr; pc = v.pc;
    wr_en = v.we; wr_addr = v.wa; wr_rel = v.wrel; wr_data = v.wd;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic lookup(input string name, input int addr, input int p,
                        input logic eh, input int et);
    drive(1'b0, mk(1, addr, p, 0, 0, 0, 0, 1, eh, et));
    check({name, " valid"}, int'(lk_valid), 1);
    check({name, " hit"}, int'(lk_hit), int'(eh));
    check({name, " target"}, int'(target), et);
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 5,    0, 0, 0, 0,    1, 1, 0);
    vecs[1]  = mk(1, 1, 5,    0, 0, 0, 0,    1, 1, 9);
    vecs[2]  = mk(1, 2, 5,    0, 0, 0, 0,    1, 1, 17);
    vecs[3]  = mk(1, 3, 5,    0, 0, 0, 0,    1, 0, 6);
    vecs[4]  = mk(0, 0, 0,    1, 4, 1, 1023, 0, 0, 6);
    vecs[5]  = mk(1, 4, 4,    0, 0, 0, 0,    1, 1, 3);
    vecs[6]  = mk(1, 4, 0,    0, 0, 0, 0,    1, 1, 1023);
    vecs[7]  = mk(0, 0, 0,    1, 5, 1, 20,   0, 1, 1023);
    vecs[8]  = mk(1, 5, 1010, 0, 0, 0, 0,    1, 1, 6);
    vecs[9]  = mk(0, 0, 0,    1, 7, 1, 1019, 0, 1, 6);
    vecs[10] = mk(1, 7, 2,    0, 0, 0, 0,    1, 1, 1021);
    vecs[11] = mk(1, 1, 5,    1, 1, 0, 300,  1, 1, 300);
    vecs[12] = mk(1, 6, 1023, 0, 0, 0, 0,    1, 0, 0);
    vecs[13] = mk(0, 0, 0,    1, 6, 0, 50,   0, 0, 0);
    vecs[14] = mk(1, 6, 1023, 0, 0, 0, 0,    1, 1, 50);
    vecs[15] = mk(1, 3, 7,    1, 8, 0, 100,  1, 0, 8);

    Reset = 1'b1; lk_req = 1'b0; lk_addr = '0; pc = '0;
    wr_en = 1'b0; wr_addr = '0; wr_rel = 1'b0; wr_data = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset valid", int'(lk_valid), 0);
    check("reset hit", int'(lk_hit), 0);
    check("reset target", int'(target), 0);

    for (int i = 0; i < 16; i++) begin
      drive(1'b0, vecs[i]);
      check($sformatf("vec%0d valid", i), int'(lk_valid), int'(vecs[i].ev));
      check($sformatf("vec%0d hit", i), int'(lk_hit), int'(vecs[i].eh));
      check($sformatf("vec%0d target", i), int'(target), int'(vecs[i].et));
    end

    // Collision write must have landed; the old value is gone for good.
    lookup("addr1 after bypass", 1, 0, 1'b1, 300);
    lookup("addr8 written", 8, 0, 1'b1, 100);

    // Overwrite a default, then reset with a lookup and a write pending.
    drive(1'b0, mk(0, 0, 0, 1, 2, 0, 77, 0, 0, 0));
    lookup("addr2 overwritten", 2, 0, 1'b1, 77);
    drive(1'b1, mk(1, 2, 5, 1, 9, 0, 123, 0, 0, 0));
    check("reset drop valid", int'(lk_valid), 0);
    check("reset drop target", int'(target), 0);
    idle();
    check("post reset no pulse", int'(lk_valid), 0);
    lookup("addr2 restored", 2, 5, 1'b1, 17);
    lookup("addr1 restored", 1, 5, 1'b1, 9);
    lookup("addr9 reset write ignored", 9, 1023, 1'b0, 0);
    lookup("addr4 cleared", 4, 4, 1'b0, 5);
    idle();
    check("hold valid", int'(lk_valid), 0);
    check("hold hit", int'(lk_hit), 0);
    check("hold target", int'(target), 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
